// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: stall/flush/forward control for a 5-stage pipeline,
// including an iterative-divider stall sequencer and precise exception flush.
module hazard_scoreboard #(
  parameter int unsigned AW          = 5,
  parameter int unsigned DIV_LAT     = 33,
  parameter bit          BRANCH_IN_D = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,

  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic          use_rsD,
  input  logic          use_rtD,
  input  logic          branchD,
  input  logic          regjumpD,

  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] writeregE,
  input  logic          regwriteE,
  input  logic          memtoregE,
  input  logic          div_startE,

  input  logic [AW-1:0] writeregM,
  input  logic          regwriteM,
  input  logic          memtoregM,
  input  logic          exceptM,

  input  logic [AW-1:0] writeregW,
  input  logic          regwriteW,

  input  logic          i_stall,
  input  logic          d_stall,

  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          stallM,
  output logic          stallW,
  output logic          flushD,
  output logic          flushE,
  output logic          flushM,
  output logic          flushW,
  output logic          flush_pc_sel,

  output logic          forwardaD,
  output logic          forwardbD,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,

  output logic          div_busy,
  output logic          div_doneE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] CntLoad = 8'(DIV_LAT - 1);

  logic [1:0] stateQ, stateD;
  logic [7:0] cntQ, cntD;
  logic       flushPendQ, flushPendD;

  logic freeze;
  logic flushIssue;
  logic divStall;
  logic lwStall;
  logic brStall;

  // A result the branch comparator would need that is not yet available in D:
  // an ALU result still in E, or a load result still in M.
  function automatic logic pendingWrite(input logic [AW-1:0] r);
    logic inE, inM;
    inE = regwriteE & (writeregE != '0) & (writeregE == r);
    inM = memtoregM & (writeregM != '0) & (writeregM == r);
    return inE | inM;
  endfunction

  function automatic logic [1:0] fwdSelE(input logic [AW-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if ((r != '0) && regwriteM && (writeregM == r)) begin
      sel = 2'b10;
    end else if ((r != '0) && regwriteW && (writeregW == r)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign freeze     = i_stall | d_stall;
  assign flushIssue = (exceptM | flushPendQ) & ~freeze;

  assign lwStall = memtoregE & regwriteE & (writeregE != '0) &
                   ((use_rsD & (writeregE == rsD)) | (use_rtD & (writeregE == rtD)));

  assign brStall = BRANCH_IN_D &
                   ((branchD & (pendingWrite(rsD) | pendingWrite(rtD))) |
                    (regjumpD & pendingWrite(rsD)));

  assign divStall = ((stateQ == IDLE) & div_startE & ~freeze) | (stateQ == BUSY);

  assign div_busy  = (stateQ != IDLE);
  assign div_doneE = (stateQ == DONE);

  // Forwarding
  assign forwardaD = BRANCH_IN_D & (rsD != '0) & regwriteM & (writeregM == rsD);
  assign forwardbD = BRANCH_IN_D & (rtD != '0) & regwriteM & (writeregM == rtD);
  assign forwardaE = fwdSelE(rsE);
  assign forwardbE = fwdSelE(rtE);

  // Divider sequencer next state; an issued exception flush aborts any division.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    if (flushIssue) begin
      stateD = IDLE;
      cntD   = 8'd0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (div_startE && !freeze) begin
            stateD = BUSY;
            cntD   = CntLoad;
          end
        end
        BUSY: begin
          if (!freeze) begin
            cntD = cntQ - 8'd1;
            if (cntQ == 8'd1) begin
              stateD = DONE;
            end
          end
        end
        DONE: begin
          if (!freeze) begin
            stateD = IDLE;
          end
        end
        default: begin
          stateD = IDLE;
          cntD   = 8'd0;
        end
      endcase
    end
  end

  // An exception seen while frozen must be replayed once the freeze lifts.
  always_comb begin
    flushPendD = flushPendQ;
    if (flushIssue) begin
      flushPendD = 1'b0;
    end else if (exceptM && freeze) begin
      flushPendD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ     <= IDLE;
      cntQ       <= 8'd0;
      flushPendQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      flushPendQ <= flushPendD;
    end
  end

  // Stall/flush arbitration: exception > freeze > divider > load/branch hazard.
  always_comb begin
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    stallW       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    flushM       = 1'b0;
    flushW       = 1'b0;
    flush_pc_sel = 1'b0;
    if (flushIssue) begin
      flushD       = 1'b1;
      flushE       = 1'b1;
      flushM       = 1'b1;
      flushW       = 1'b1;
      flush_pc_sel = 1'b1;
    end else if (freeze) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (divStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (lwStall || brStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter DIV_LAT, default 33, divider stall cycles; legal range 2..255.
REQ-003 Parameter BRANCH_IN_D, default 1; 1 resolves branch/jr in D (stall and D-forward), 0 resolves in E (no branch stall).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 rsD, rtD  in  AW each  D-stage source registers; use_rsD, use_rtD  in  1 each  source actually read.
REQ-007 branchD, regjumpD  in  1 each  D holds conditional branch / register jump.
REQ-008 rsE, rtE, writeregE  in  AW each; regwriteE, memtoregE, div_startE  in  1 each.
REQ-009 writeregM  in  AW; regwriteM, memtoregM, exceptM  in  1 each.
REQ-010 writeregW  in  AW; regwriteW  in  1.
REQ-011 i_stall, d_stall  in  1 each  instruction/data SRAM not ready.
REQ-012 stallF, stallD, stallE, stallM, stallW  out  1 each  hold stage register.
REQ-013 flushD, flushE, flushM, flushW  out  1 each  clear stage register; flush_pc_sel  out  1  fetch from exception vector.
REQ-014 forwardaD, forwardbD  out  1 each; forwardaE, forwardbE  out  2 each (00 regfile, 01 W, 10 M).
REQ-015 div_busy, div_doneE  out  1 each.

Function
REQ-016 Forwarding: address 0 never forwarded; E prefers M over W; D forwards from M only, and only when BRANCH_IN_D=1 (else 0).
REQ-017 freeze = i_stall | d_stall; while freeze and no exception flush is issued: all five stalls 1, all flushes 0.
REQ-018 lwstall = memtoregE & regwriteE & writeregE!=0 & ((use_rsD & writeregE==rsD) | (use_rtD & writeregE==rtD)).
REQ-019 brstall (BRANCH_IN_D=1 only) = (branchD uses rs,rt; regjumpD uses rs) matching writeregE!=0 with regwriteE, or writeregM!=0 with memtoregM.
REQ-020 Divider FSM states IDLE, BUSY, DONE; reset to IDLE, 8-bit counter cnt=0.
REQ-021 IDLE: div_startE & ~freeze -> BUSY, cnt<=DIV_LAT-1; div_stall=1 that cycle.
REQ-022 BUSY: div_stall=1; cnt decrements when ~freeze; at cnt==1 and ~freeze -> DONE.
REQ-023 DONE: div_stall=0, div_doneE=1; ~freeze -> IDLE (div_startE ignored that cycle); freeze -> hold DONE.
REQ-024 Total: exactly DIV_LAT stall cycles from start, then one DONE cycle, absent freeze.
REQ-025 div_busy = state!=IDLE.
REQ-026 div_stall: stallF,D,E=1, flushE=0, M,W advance with flushM=1 (bubble).
REQ-027 Hazard stall (lwstall|brstall, no div_stall, no freeze): stallF,D=1, flushE=1.
REQ-028 Exception: flush issued when (exceptM | flush_pend) & ~freeze: flushD,E,M,W=1, flush_pc_sel=1, all stalls 0, FSM -> IDLE, cnt<=0; one cycle only.
REQ-029 exceptM & freeze sets flush_pend; flush_pend clears on the cycle the flush issues; repeated exceptM while pending has no added effect.
REQ-030 Priority: exception flush > freeze > div_stall > hazard stall > none.

Reset
REQ-031 resetn low asynchronously forces IDLE, cnt=0, flush_pend=0; all registered outputs 0 while asserted.
REQ-032 Reset mid-division or with flush pending discards it; no flush or div_doneE after release.
REQ-033 With all inputs 0, every output is 0.

Verification
REQ-034 memtoregE=1, regwriteE=1, writeregE=5, rsD=5, use_rsD=1 -> stallF=stallD=flushE=1 one cycle; writeregE=0 -> no stall.
REQ-035 DIV_LAT=4, div_startE pulse at cycle 0 -> stallE=1 cycles 0..3, div_doneE=1 cycle 4, IDLE cycle 5.
REQ-036 DIV_LAT=4, start then d_stall=1 for cycles 1..2 -> div_doneE on cycle 6, held through any freeze.
REQ-037 exceptM=1 with i_stall=1 for 3 cycles -> no flush during freeze; flushD..W=flush_pc_sel=1 exactly one cycle after i_stall drops.
REQ-038 BRANCH_IN_D=0, branchD=1, regwriteE=1, writeregE=rsD=3 -> no stall, forwardaD=0.
REQ-039 resetn low during BUSY (cnt=2) -> div_busy=0 immediately; no div_doneE after release.
